// File: rtl/phase_unwrap_if.sv
// rtl/phase_unwrap_if.sv - handshake bundle for the phase unwrap stage
//
// Purpose: groups the input angle stream and the output result stream.
// Signals:
//   in_valid / in_ready / in_angle                  wrapped angle stream into the stage
//   out_valid / out_ready / out_delta / out_phase / out_turns   result stream out of the stage
// Modports:
//   slave  - the phase_unwrap stage itself
//   master - the environment that feeds angles and drains results
interface phase_unwrap_if #(
   parameter int AW = 32,
   parameter int PW = 48,
   parameter int TW = 16
);
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] in_angle;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_delta;
   logic [PW-1:0] out_phase;
   logic [TW-1:0] out_turns;

   modport slave (
      input  in_valid, in_angle, out_ready,
      output in_ready, out_valid, out_delta, out_phase, out_turns
   );

   modport master (
      output in_valid, in_angle, out_ready,
      input  in_ready, out_valid, out_delta, out_phase, out_turns
   );
endinterface

// File: rtl/phase_unwrap.sv
// rtl/phase_unwrap.sv - wrapped-angle to unwrapped-phase tracking stage
//
// Purpose: takes wrapped angles in degrees (LSB = 2^-FRAC deg), emits the
// shortest-path step, the accumulated unwrapped phase and a signed count of
// +/-180 deg boundary crossings. One output register stage, 1 sample/clk.
// Ports:
//   clk    - clock, all state on rising edge
//   rst_n  - asynchronous active-low reset
//   clear  - synchronous restart: forget previous sample, zero phase/turns,
//            drop any pending output, block input for this cycle
//   bus    - phase_unwrap_if.slave: in_valid/in_ready/in_angle input stream,
//            out_valid/out_ready/out_delta/out_phase/out_turns output stream
module phase_unwrap #(
   parameter int AW   = 32,
   parameter int FRAC = 23,
   parameter int PW   = 48,
   parameter int TW   = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clear,
   phase_unwrap_if.slave  bus
);
   // Half and full turn at AW+1 bits so the raw difference never overflows.
   localparam logic signed [AW:0] HALF     = (AW+1)'(180) << FRAC;
   localparam logic signed [AW:0] FULL     = (AW+1)'(360) << FRAC;
   localparam logic signed [AW:0] NEG_HALF = -HALF;
   // Step correction is done modulo 2^AW; only the low bits of FULL matter.
   localparam logic [AW-1:0]      FULL_LO  = FULL[AW-1:0];

   typedef enum logic {
      EMPTY = 1'b0,
      RUN   = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic signed [AW-1:0] prev_q, prev_d;
   logic [AW-1:0]        delta_q, delta_d;
   logic [PW-1:0]        phase_q, phase_d;
   logic [TW-1:0]        turns_q, turns_d;
   logic                 valid_q, valid_d;

   logic signed [AW:0]   raw;
   logic [AW-1:0]        step;
   logic                 wrap_dn;
   logic                 wrap_up;
   logic                 take;

   assign bus.in_ready = !clear && (!valid_q || bus.out_ready);
   assign take         = bus.in_valid && bus.in_ready;

   assign raw     = {bus.in_angle[AW-1], bus.in_angle} - {prev_q[AW-1], prev_q};
   // raw == +HALF folds to -HALF; raw == -HALF is kept as is.
   assign wrap_dn = (raw >= HALF);
   assign wrap_up = (raw < NEG_HALF);

   always_comb begin
      step = raw[AW-1:0];
      if (wrap_dn) begin
         step = raw[AW-1:0] - FULL_LO;
      end else if (wrap_up) begin
         step = raw[AW-1:0] + FULL_LO;
      end
   end

   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      delta_d = delta_q;
      phase_d = phase_q;
      turns_d = turns_q;
      valid_d = valid_q && !bus.out_ready;

      if (clear) begin
         state_d = EMPTY;
         prev_d  = '0;
         delta_d = '0;
         phase_d = '0;
         turns_d = '0;
         valid_d = 1'b0;
      end else if (take) begin
         valid_d = 1'b1;
         prev_d  = bus.in_angle;
         state_d = RUN;
         if (state_q == EMPTY) begin
            // First sample after reset/clear anchors the phase; no step.
            delta_d = '0;
            phase_d = {{(PW-AW){bus.in_angle[AW-1]}}, bus.in_angle};
         end else begin
            delta_d = step;
            phase_d = phase_q + {{(PW-AW){step[AW-1]}}, step};
            if (wrap_dn) begin
               turns_d = turns_q - TW'(1);
            end else if (wrap_up) begin
               turns_d = turns_q + TW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         prev_q  <= '0;
         delta_q <= '0;
         phase_q <= '0;
         turns_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         delta_q <= delta_d;
         phase_q <= phase_d;
         turns_q <= turns_d;
         valid_q <= valid_d;
      end
   end

   assign bus.out_valid = valid_q;
   assign bus.out_delta = delta_q;
   assign bus.out_phase = phase_q;
   assign bus.out_turns = turns_q;
endmodule

// File: tb/tb_phase_unwrap.sv
// tb/tb_phase_unwrap.sv - self-checking bench for phase_unwrap
module tb_phase_unwrap;
   localparam int AW = 32;
   localparam int PW = 48;
   localparam int TW = 16;
   localparam longint HALF_L = longint'(180) << 23;
   localparam longint FULL_L = longint'(360) << 23;

   typedef struct {
      logic [31:0] d;
      logic [47:0] p;
      logic [15:0] t;
   } res_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;
   bit   rand_rdy = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;
   int n_acc   = 0;

   res_t q_exp[$];
   res_t got[$];

   bit          m_first = 1'b1;
   longint      m_prev  = 0;
   longint      m_phase = 0;
   logic [15:0] m_turns = '0;

   phase_unwrap_if #(.AW(AW), .PW(PW), .TW(TW)) bus ();

   phase_unwrap #(.AW(AW), .FRAC(23), .PW(PW), .TW(TW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      q_exp.delete();
      m_first = 1'b1;
      m_prev  = 0;
      m_phase = 0;
      m_turns = '0;
   endtask

   // Reference: shortest-path step by folding the plain difference into
   // [-180, 180) deg, one full turn at a time, counting each fold.
   task automatic model_accept(input logic [31:0] angle);
      longint a, d;
      res_t r;
      a = longint'($signed(angle));
      if (m_first) begin
         d = 0;
         m_phase = a;
         m_first = 1'b0;
      end else begin
         d = a - m_prev;
         while (d >= HALF_L) begin
            d = d - FULL_L;
            m_turns = m_turns - 16'd1;
         end
         while (d < -HALF_L) begin
            d = d + FULL_L;
            m_turns = m_turns + 16'd1;
         end
         m_phase = m_phase + d;
      end
      m_prev = a;
      r.d = d[31:0];
      r.p = m_phase[47:0];
      r.t = m_turns;
      q_exp.push_back(r);
   endtask

   // Compare process: mid-cycle sampling, every cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         model_reset();
         check("rst_valid", {63'd0, bus.out_valid}, 64'd0);
         check("rst_phase", {16'd0, bus.out_phase}, 64'd0);
         check("rst_turns", {48'd0, bus.out_turns}, 64'd0);
         check("rst_delta", {32'd0, bus.out_delta}, 64'd0);
      end else begin
         check("in_ready", {63'd0, bus.in_ready},
               {63'd0, (!clear && (!bus.out_valid || bus.out_ready))});
         if (bus.out_valid) begin
            if (q_exp.size() == 0) begin
               check("unexpected_out", 64'd1, 64'd0);
            end else begin
               check("delta", {32'd0, bus.out_delta}, {32'd0, q_exp[0].d});
               check("phase", {16'd0, bus.out_phase}, {16'd0, q_exp[0].p});
               check("turns", {48'd0, bus.out_turns}, {48'd0, q_exp[0].t});
               if (bus.out_ready) begin
                  res_t g;
                  g.d = bus.out_delta;
                  g.p = bus.out_phase;
                  g.t = bus.out_turns;
                  got.push_back(g);
                  void'(q_exp.pop_front());
               end
            end
         end else if (q_exp.size() != 0) begin
            check("lost_out", 64'd0, 64'd1);
         end
         if (clear) begin
            model_reset();
         end else if (bus.in_valid && bus.in_ready) begin
            n_acc++;
            model_accept(bus.in_angle);
         end
      end
   end

   always @(posedge clk) begin
      if (rand_rdy) begin
         #1;
         bus.out_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic send(input logic [31:0] a);
      bit ok;
      ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_angle = a;
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge clk);
         if (bus.in_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      if (!ok) check("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain();
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 200 && !ok; k++) begin
         if (q_exp.size() == 0 && !bus.out_valid) ok = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      if (!ok) check("drain_timeout", 64'd0, 64'd1);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
   endtask

   task automatic chk_out(input string tag, input int idx, input logic [31:0] d,
                          input logic [47:0] p, input logic [15:0] t);
      if (idx >= got.size()) begin
         check({tag, "_missing"}, 64'(got.size()), 64'(idx + 1));
      end else begin
         check({tag, "_delta"}, {32'd0, got[idx].d}, {32'd0, d});
         check({tag, "_phase"}, {16'd0, got[idx].p}, {16'd0, p});
         check({tag, "_turns"}, {48'd0, got[idx].t}, {48'd0, t});
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      bit done;
      longint w;
      bus.in_valid  = 1'b0;
      bus.in_angle  = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Two simple samples, 10 then 30 deg.
      got.delete();
      send(32'd83886080);
      send(32'd251658240);
      drain();
      check("t1_count", 64'(got.size()), 64'd2);
      chk_out("t1_0", 0, 32'd0, 48'd83886080, 16'd0);
      chk_out("t1_1", 1, 32'd167772160, 48'd251658240, 16'd0);

      // Positive wrap across +/-180.
      do_clear();
      got.delete();
      send(32'd1426063360);
      send(-32'sd1426063360);
      drain();
      chk_out("wrap", 1, 32'd167772160, 48'd1593835520, 16'd1);

      // Exact half-turn folds to -180.
      do_clear();
      got.delete();
      send(-32'sd754974720);
      send(32'd754974720);
      drain();
      chk_out("half", 1, -32'sd1509949440, 48'(-64'sd2264924160), 16'hFFFF);

      // Backpressure with three offered samples.
      do_clear();
      got.delete();
      bus.out_ready = 1'b0;
      base = n_acc;
      done = 1'b0;
      fork
         begin
            send(32'd83886080);
            send(32'd167772160);
            send(32'd251658240);
            done = 1'b1;
         end
      join_none
      repeat (5) @(posedge clk);
      #1;
      check("bp_accepted", 64'(n_acc - base), 64'd1);
      check("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
      check("bp_valid", {63'd0, bus.out_valid}, 64'd1);
      bus.out_ready = 1'b1;
      for (int k = 0; k < 100 && !done; k++) begin
         @(posedge clk);
         #1;
      end
      check("bp_done", {63'd0, done}, 64'd1);
      drain();
      check("bp_count", 64'(got.size()), 64'd3);
      chk_out("bp_0", 0, 32'd0, 48'd83886080, 16'd0);
      chk_out("bp_1", 1, 32'd83886080, 48'd167772160, 16'd0);
      chk_out("bp_2", 2, 32'd83886080, 48'd251658240, 16'd0);

      // Clear together with a valid sample mid-stream.
      send(32'd83886080);
      send(32'd167772160);
      clear = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_angle = 32'd830472192;
      @(negedge clk);
      check("clr_in_ready", {63'd0, bus.in_ready}, 64'd0);
      @(posedge clk);
      #1;
      clear = 1'b0;
      bus.in_valid = 1'b0;
      check("clr_valid", {63'd0, bus.out_valid}, 64'd0);
      got.delete();
      send(32'd377487360);
      drain();
      check("clr_count", 64'(got.size()), 64'd1);
      chk_out("clr", 0, 32'd0, 48'd377487360, 16'd0);

      // Ramp of 400 one-degree steps starting at 0.
      do_clear();
      got.delete();
      for (int k = 0; k <= 400; k++) begin
         send(32'((((k + 180) % 360) - 180) * 8388608));
      end
      drain();
      check("ramp_count", 64'(got.size()), 64'd401);
      chk_out("ramp_end", 400, 32'd8388608, 48'd3355443200, 16'd1);
      for (int k = 1; k < got.size(); k++) begin
         check("ramp_delta", {32'd0, got[k].d}, 64'd8388608);
      end

      // Random angles and random downstream stalls.
      do_clear();
      rand_rdy = 1'b1;
      w = 0;
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 49) == 0) do_clear();
         if ($urandom_range(0, 1) == 0) begin
            w = longint'($urandom_range(0, 32'd3019898879)) - HALF_L;
         end else begin
            w = w + longint'($urandom_range(0, 32'd1006632960)) - (longint'(60) << 23);
            while (w >= HALF_L) w = w - FULL_L;
            while (w < -HALF_L) w = w + FULL_L;
         end
         send(w[31:0]);
      end
      rand_rdy = 1'b0;
      @(posedge clk);
      #2;
      bus.out_ready = 1'b1;
      drain();

      // Asynchronous reset with a result pending.
      bus.out_ready = 1'b0;
      send(32'd251658240);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", {63'd0, bus.out_valid}, 64'd0);
      check("arst_phase", {16'd0, bus.out_phase}, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      got.delete();
      send(32'd377487360);
      drain();
      chk_out("arst", 0, 32'd0, 48'd377487360, 16'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/phase_unwrap.md
Name: phase_unwrap

Overview:
Sequential stage directly downstream of the arctan angle unit. It consumes a stream of wrapped angles in degrees and produces three outputs per sample: the shortest-path phase step, the unwrapped accumulated phase, and a signed full-turn count. It is used for phase tracking and frequency estimation after the arctan stage. Valid/ready handshakes on both sides, one output register stage.

Parameters:
AW, 32, angle width; signed two's-complement degrees.
FRAC, 23, fractional bits of angle (LSB = 2^-FRAC deg); HALF = 180<<FRAC, FULL = 360<<FRAC derived internally.
PW, 48, width of the unwrapped phase accumulator.
TW, 16, width of the signed turn counter.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous restart; forgets the previous sample, zeroes phase and turns
in_valid  in  1  in_angle valid
in_ready  out  1  stage can accept this cycle
in_angle  in  AW  wrapped angle, legal range [-HALF, HALF)
out_valid  out  1  output register holds a result
out_ready  in  1  downstream accepts
out_delta  out  AW  wrapped phase step, range [-HALF, HALF)
out_phase  out  PW  unwrapped phase, same LSB as in_angle
out_turns  out  TW  signed net count of +/-180 boundary crossings

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_delta=0, out_phase=0, out_turns=0. FSM goes to EMPTY. The previous-angle register is cleared.
- in_ready = !out_valid || out_ready (combinational). A transfer occurs when in_valid && in_ready. An output is consumed when out_valid && out_ready.
- Latency is 1 cycle: accepted sample at edge N appears at outputs with out_valid=1 after edge N. Full throughput of 1 sample/clk when out_ready is held high.
- The output register holds stable while out_valid && !out_ready. out_valid drops after consumption when there is no new transfer in the same cycle.
- FSM:
  - EMPTY (no previous sample). On transfer: delta=0, phase=sign-extend(in_angle), turns unchanged (0). Store prev=in_angle, go to RUN.
  - RUN. On transfer:
    - raw = in_angle - prev, computed at AW+1 bits.
    - If raw >= HALF: delta = raw - FULL, turns -= 1.
    - Else if raw < -HALF: delta = raw + FULL, turns += 1.
    - Else: delta = raw.
    - phase += sign-extend(delta). Store prev=in_angle.
- Arithmetic rules:
  - raw exactly +HALF maps to -HALF (turns -1). raw exactly -HALF is unchanged.
  - out_phase wraps modulo 2^PW. out_turns wraps modulo 2^TW. There is no saturation.
- clear:
  - Effective only when asserted with rst_n high.
  - Next state is EMPTY; phase, turns and prev go to 0; out_valid goes to 0. Any pending output is discarded.
  - in_ready is forced 0 while clear=1, so a simultaneous in_valid is not accepted.
- in_angle outside [-HALF, HALF) is undefined input; the implementation must not hang, and results are don't-care.
- Reset mid-stream discards all state immediately, regardless of handshake.

Test Plan:
- Reset, then send 10.0 deg (83886080) then 30.0 deg (251658240), out_ready=1 -> outputs: delta=0, phase=83886080, turns=0; then delta=167772160, phase=251658240, turns=0, each 1 cycle after acceptance.
- Positive wrap: 170 deg (1426063360) then -170 deg (-1426063360) -> second output delta=+167772160 (20 deg), phase=1593835520 (190 deg), turns=+1.
- Exact half-turn: -90 deg then +90 deg -> raw=+HALF, delta=-1509949440 (-180 deg), phase=-2264924160 (-270 deg), turns=-1.
- Backpressure: out_ready=0 with 3 samples offered -> first accepted, in_ready=0 thereafter, outputs frozen. Raise out_ready -> remaining samples accepted one per cycle, none lost or duplicated.
- Clear asserted together with in_valid mid-stream -> sample not accepted, out_valid=0. Next sample 45 deg -> delta=0, phase=377487360, turns=0.
- Long ramp: 400 steps of +1 deg from 0 -> final phase=400<<23, turns=+1 (one crossing at 180 deg), delta=8388608 on every sample after the first.
